// File: rtl/axis_pkg.sv
// Shared types for the AXI-Stream packetizer: release-cause encoding and statistics width.
package axis_pkg;

   localparam int STAT_WIDTH = 32;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      LEN  = 2'd1,
      DATA = 2'd2,
      TMO  = 2'd3
   } rel_cause_t;

endpackage

// File: rtl/axis_idle_timer.sv
// Saturating idle counter; o_expired is raised once the count reaches a non-zero timeout.
module axis_idle_timer
   import axis_pkg::*;
#(
   parameter int TMO_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_clr,
   input  logic                 i_en,
   input  logic [TMO_WIDTH-1:0] i_timeout,
   output logic                 o_expired
);

   logic [TMO_WIDTH-1:0] r_timer;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer <= '0;
      end else if (i_clr) begin
         r_timer <= '0;
      end else if (i_en && (r_timer != '1)) begin
         r_timer <= r_timer + TMO_WIDTH'(1);
      end
   end

   assign o_expired = (i_timeout != '0) && (r_timer >= i_timeout);

endmodule

// File: rtl/axis_packetizer.sv
// Frames an unframed AXI-Stream into packets by length or idle timeout.
// Define AXIS_PACKETIZER_STATS_EN to build the packet / timeout counters.
module axis_packetizer
   import axis_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 8,
   parameter int TMO_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   output logic                  m_tlast,
   input  logic                  m_tready,
   input  logic [LEN_WIDTH-1:0]  pkt_len,
   input  logic [TMO_WIDTH-1:0]  timeout,
   output logic [STAT_WIDTH-1:0] pkt_count,
   output logic [STAT_WIDTH-1:0] tmo_count
);

   generate
      if (DATA_WIDTH < 1) begin : g_bad_width
         $error("axis_packetizer: DATA_WIDTH must be >= 1");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] r_h_data;
   logic                  r_h_v;
   logic [DATA_WIDTH-1:0] r_m_tdata;
   logic                  r_m_tvalid;
   logic                  r_m_tlast;
   logic [LEN_WIDTH-1:0]  r_cnt;
   logic [LEN_WIDTH-1:0]  r_len_q;

   logic                  w_can_move;
   logic                  w_acc;
   logic                  w_expired;
   logic                  w_rel_len;
   logic                  w_rel_data;
   logic                  w_rel_tmo;
   logic                  w_rel;
   logic                  w_last;
   logic [LEN_WIDTH-1:0]  w_len_m1;
   logic [LEN_WIDTH-1:0]  w_cnt_nxt;

   assign w_can_move = !r_m_tvalid || m_tready;
   assign s_tready   = !r_h_v || w_can_move;
   assign w_acc      = s_tvalid && s_tready;

   // The hold register is always one beat behind, so a beat is only released as
   // non-last once its successor is known to exist.
   assign w_len_m1   = r_len_q - LEN_WIDTH'(1);
   assign w_rel_len  = r_h_v && w_can_move && (r_cnt == w_len_m1);
   assign w_rel_data = r_h_v && w_can_move && !w_rel_len && w_acc;
   assign w_rel_tmo  = r_h_v && w_can_move && !w_rel_len && !w_acc && w_expired;
   assign w_rel      = w_rel_len || w_rel_data || w_rel_tmo;
   assign w_last     = w_rel_len || w_rel_tmo;
   assign w_cnt_nxt  = !w_rel ? r_cnt : (w_last ? '0 : r_cnt + LEN_WIDTH'(1));

   axis_idle_timer #(
      .TMO_WIDTH (TMO_WIDTH)
   ) u_idle_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clr     (w_acc || w_rel),
      .i_en      (r_h_v),
      .i_timeout (timeout),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_h_data   <= '0;
         r_h_v      <= 1'b0;
         r_m_tdata  <= '0;
         r_m_tvalid <= 1'b0;
         r_m_tlast  <= 1'b0;
         r_cnt      <= '0;
         r_len_q    <= '0;
      end else begin
         if (w_acc) begin
            r_h_data <= s_tdata;
            r_h_v    <= 1'b1;
         end else if (w_rel) begin
            r_h_v <= 1'b0;
         end
         // Length is latched only for the first beat so mid-packet changes are ignored.
         if (w_acc && (w_cnt_nxt == '0)) begin
            r_len_q <= (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
         end
         r_cnt <= w_cnt_nxt;
         if (w_can_move) begin
            r_m_tvalid <= w_rel;
            if (w_rel) begin
               r_m_tdata <= r_h_data;
               r_m_tlast <= w_last;
            end
         end
      end
   end

   assign m_tdata  = r_m_tdata;
   assign m_tvalid = r_m_tvalid;
   assign m_tlast  = r_m_tlast;

`ifdef AXIS_PACKETIZER_STATS_EN
   rel_cause_t            r_cause;
   logic [STAT_WIDTH-1:0] r_pkt_count;
   logic [STAT_WIDTH-1:0] r_tmo_count;
   logic                  w_done;

   assign w_done = r_m_tvalid && m_tready && r_m_tlast;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cause     <= NONE;
         r_pkt_count <= '0;
         r_tmo_count <= '0;
      end else begin
         if (w_can_move) begin
            r_cause <= w_rel_len  ? LEN  :
                       w_rel_data ? DATA :
                       w_rel_tmo  ? TMO  : NONE;
         end
         if (w_done) begin
            r_pkt_count <= r_pkt_count + STAT_WIDTH'(1);
            if (r_cause == TMO) begin
               r_tmo_count <= r_tmo_count + STAT_WIDTH'(1);
            end
         end
      end
   end

   assign pkt_count = r_pkt_count;
   assign tmo_count = r_tmo_count;
`else
   assign pkt_count = '0;
   assign tmo_count = '0;
`endif

endmodule
